updown_mod_counter: RTL and testbench

- Parametrised successor to the 4-bit enable counter: a WIDTH-bit modulo-N up/down counter with synchronous parallel load and wrap or saturate mode.
- Adds a cascade carry input, a combinational ripple carry out for chaining digits, and a sticky overflow flag.
- Used as a standalone counter and as the per-digit cell of multi-digit (e.g. BCD) counter chains in the counters lab.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_next_value.sv | 49 ++++
 rtl/updown_mod_counter.sv | 83 ++++++++
 tb/tb_updown_mod_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction/mode encodings and
// the load-value clamp used by every modulo counter variant.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Clamp a requested load value into the legal count range 0..modulus-1.
    function automatic int clamp_load(input int value, input int modulus);
        return (value >= modulus) ? (modulus - 1) : value;
    endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-value generator for a modulo-N up/down counter.
// Reports whether the current value is the terminal value for the
// selected direction; a step from there is a boundary event.
module counter_next_value
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_up_down,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_terminal
);

    // One extra bit so MODULUS = 2**WIDTH is representable and A+1 never
    // aliases back into range before the terminal compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_inc = {1'b0, i_a} + (WIDTH+1)'(1);
    assign w_dec = i_a - WIDTH'(1);

    // Select increment/decrement, applying wrap or saturate at the terminal value.
    always_comb begin
        o_terminal = 1'b0;
        o_next     = i_a;
        if (i_up_down == DIR_UP) begin
            o_terminal = (w_inc == MOD_EXT);
            if (!o_terminal) begin
                o_next = w_inc[WIDTH-1:0];
            end else if (i_mode == MODE_WRAP) begin
                o_next = '0;
            end
        end else begin
            o_terminal = (i_a == '0);
            if (!o_terminal) begin
                o_next = w_dec;
            end else if (i_mode == MODE_WRAP) begin
                o_next = MAX_VAL;
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with parallel load, wrap or
// saturate mode, cascade carry in/out and a sticky overflow flag.
// Chain digits by driving each stage's carry_in from the stage below's
// output_carry; the whole chain advances in one clock.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             count_enable,
    input  logic             carry_in,
    input  logic             up_down,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] A,
    output logic             output_carry,
    output logic             terminal_count,
    output logic             overflow
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_a;
    logic             r_overflow;
    logic [WIDTH-1:0] w_next;
    logic             w_terminal;
    logic             w_step;
    logic             w_boundary;
    logic [WIDTH-1:0] w_load_clamped;

    counter_next_value #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_a        (r_a),
        .i_up_down  (up_down),
        .i_mode     (mode),
        .o_next     (w_next),
        .o_terminal (w_terminal)
    );

    // Load has priority over counting, so a load cycle never steps.
    assign w_step         = count_enable & carry_in & ~load;
    assign w_boundary     = w_step & w_terminal;
    assign w_load_clamped = WIDTH'(clamp_load(32'(load_value), MODULUS));

    // Count register: reset > load > step > hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a <= '0;
        end else if (load) begin
            r_a <= w_load_clamped;
        end else if (w_step) begin
            r_a <= w_next;
        end
    end

    // Sticky overflow: a boundary event wins over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_boundary) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign A              = r_a;
    assign overflow       = r_overflow;
    assign terminal_count = w_terminal;
    // Ripple carry is combinational so a chain of digits steps together;
    // it is suppressed while loading because this stage is not stepping.
    assign output_carry   = w_boundary;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clock = 1'b0;
    logic         reset, count_enable, carry_in, up_down, mode, load, clear_overflow;
    logic [W-1:0] load_value;
    logic [W-1:0] A;
    logic         output_carry, terminal_count, overflow;

    // cascade pair
    logic         c_reset, c_en;
    logic [W-1:0] lo_a, hi_a;
    logic         lo_carry, lo_tc, lo_ovf, hi_carry, hi_tc, hi_ovf;

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clock(clock), .reset(reset), .count_enable(count_enable), .carry_in(carry_in),
        .up_down(up_down), .mode(mode), .load(load), .load_value(load_value),
        .clear_overflow(clear_overflow), .A(A), .output_carry(output_carry),
        .terminal_count(terminal_count), .overflow(overflow)
    );

    updown_mod_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
        .clock(clock), .reset(c_reset), .count_enable(c_en), .carry_in(1'b1),
        .up_down(1'b1), .mode(1'b0), .load(1'b0), .load_value('0),
        .clear_overflow(1'b0), .A(lo_a), .output_carry(lo_carry),
        .terminal_count(lo_tc), .overflow(lo_ovf)
    );

    updown_mod_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
        .clock(clock), .reset(c_reset), .count_enable(c_en), .carry_in(lo_carry),
        .up_down(1'b1), .mode(1'b0), .load(1'b0), .load_value('0),
        .clear_overflow(1'b0), .A(hi_a), .output_carry(hi_carry),
        .terminal_count(hi_tc), .overflow(hi_ovf)
    );

    typedef struct {
        int a;
        int tc;
        int carry;
        int ovf;
        int lo;
        int hi;
        int hi_carry;
        int hi_ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    int m_a   = 0;
    int m_ovf = 0;
    int c_n   = 0;
    int c_hovf = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("A", int'(A), e.a);
                chk("terminal_count", int'(terminal_count), e.tc);
                chk("output_carry", int'(output_carry), e.carry);
                chk("overflow", int'(overflow), e.ovf);
                chk("cascade_lo", int'(lo_a), e.lo);
                chk("cascade_hi", int'(hi_a), e.hi);
                chk("cascade_hi_carry", int'(hi_carry), e.hi_carry);
                chk("cascade_hi_overflow", int'(hi_ovf), e.hi_ovf);
            end
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic cyc(input bit rst, input bit en, input bit cin, input bit ud,
                       input bit md, input bit ld, input int lv, input bit clr);
        exp_t e;
        bit   tc, step;
        reset          = rst;
        count_enable   = en;
        carry_in       = cin;
        up_down        = ud;
        mode           = md;
        load           = ld;
        load_value     = W'(lv);
        clear_overflow = clr;

        tc   = ud ? (m_a == M - 1) : (m_a == 0);
        step = en && cin && !ld;
        e.a        = m_a;
        e.tc       = int'(tc);
        e.carry    = int'(step && tc);
        e.ovf      = m_ovf;
        e.lo       = c_n % 10;
        e.hi       = c_n / 10;
        e.hi_carry = int'(c_en && (c_n == 99));
        e.hi_ovf   = c_hovf;
        exp_q.push_back(e);

        if (rst) begin
            m_a   = 0;
            m_ovf = 0;
        end else begin
            if (step && tc) m_ovf = 1;
            else if (clr)   m_ovf = 0;
            if (ld) begin
                m_a = (lv >= M) ? M - 1 : lv;
            end else if (step) begin
                if (ud) m_a = md ? ((m_a + 1 > M - 1) ? M - 1 : m_a + 1) : (m_a + 1) % M;
                else    m_a = md ? ((m_a - 1 < 0) ? 0 : m_a - 1) : (m_a - 1 + M) % M;
            end
        end

        if (c_reset) begin
            c_n = 0;
            c_hovf = 0;
        end else if (c_en) begin
            if (c_n == 99) c_hovf = 1;
            c_n = (c_n + 1) % 100;
        end

        @(posedge clock);
        #1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; count_enable = 1'b0; carry_in = 1'b0; up_down = 1'b1;
        mode = 1'b0; load = 1'b0; load_value = '0; clear_overflow = 1'b0;
        c_reset = 1'b1; c_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        c_reset = 1'b0;
        c_en    = 1'b1;

        // reset, then wrap up-count through 9 -> 0
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        repeat (12) cyc(0, 1, 1, 1, 0, 0, 0, 0);
        // saturate down from a load of 2 (clear overflow on the load cycle)
        cyc(0, 0, 1, 0, 1, 1, 2, 1);
        repeat (4) cyc(0, 1, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0, 0);
        // load clamp beats count enable
        cyc(0, 1, 1, 1, 0, 1, 13, 0);
        // at 9 counting up with clear: set wins; then clear alone
        cyc(0, 1, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        // carry_in low blocks stepping
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        // reset mid-count at 7 with load also asserted
        cyc(0, 0, 1, 1, 0, 1, 7, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 1, 5, 0);
        repeat (2) cyc(0, 0, 1, 1, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
